memory_arbiter: RTL and testbench

Sequential arbiter that shares the single RAM port between the instruction-fetch requester (icache side) and the data requester (dcache side) of the pipelined CPU. Data requests have priority. An optional starvation counter guarantees instruction fetch progress. Each access is tracked by a small FSM, so every requester sees exactly one `wait`-low completion cycle per transaction. It sits between the caches and the RAM model, in place of the combinational memory control.

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/arbiter_if.sv | 39 +++
 rtl/arb_starve_ctr.sv | 33 +++
 rtl/memory_arbiter.sv | 141 ++++++++++++++
 tb/tb_memory_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: RAM handshake state, arbiter FSM state,
// bus owner and the word loaded on an errored or timed-out access.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {IDLE, IGNT, DGNT, RESP} arb_state_t;

  typedef enum logic {I, D} arb_owner_t;

  localparam word_t ARB_ERR_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/arbiter_if.sv
// Cache/RAM signal bundle around memory_arbiter: arb is the arbiter's view,
// cache the requester side, tb drives both the caches and the RAM model.
interface arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  word_t     iload;
  logic      iwait;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  word_t     dload;
  logic      dwait;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      ram_err;

  modport arb (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, ram_err
  );

  modport cache (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  iload, iwait, dload, dwait, ram_err
  );

  modport tb (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, ram_err
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// Counts consecutive data grants taken while a fetch is pending and raises
// o_force once LIMIT is reached, so the next arbitration goes to fetch.
module arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_dgnt_entry,
  input  logic i_ignt_entry,
  input  logic i_iren,
  output logic o_force
);

  localparam logic [7:0] CNT_LIM = 8'(LIMIT);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_ignt_entry) begin
      r_cnt <= '0;
    end else if (i_dgnt_entry) begin
      if (!i_iren)
        r_cnt <= '0;
      else if (r_cnt != 8'hFF)
        r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_force = i_iren && (r_cnt == CNT_LIM);

endmodule

// File: rtl/memory_arbiter.sv
// Shares one RAM port between fetch and data requesters, data first.
// Build with ARB_FAIRNESS_EN to force a fetch grant after STARVE_LIMIT data grants.
// state | meaning
// IDLE  | arbitrate pending requests
// IGNT  | fetch owns the RAM port
// DGNT  | data owns the RAM port
// RESP  | one-cycle completion, owner's wait low
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT      = 255,
  parameter int STARVE_LIMIT = 4
) (
  input  logic  CLK,
  input  logic  RST,
  arbiter_if.arb bus
);

  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

  arb_state_t r_state, w_next;
  arb_owner_t r_owner, w_next_owner;
  logic [7:0] r_tmo;
  word_t      r_iload, r_dload;
  logic       r_err;

  logic  w_dreq, w_own_req, w_in_grant, w_force;
  logic  w_done_ok, w_done_err;
  word_t w_load_val;

  assign w_dreq     = bus.dREN | bus.dWEN;
  assign w_own_req  = (r_owner == I) ? bus.iREN : w_dreq;
  assign w_in_grant = (r_state == IGNT) || (r_state == DGNT);

`ifdef ARB_FAIRNESS_EN
  logic w_dgnt_entry, w_ignt_entry;

  assign w_dgnt_entry = (r_state == IDLE) && (w_next == DGNT);
  assign w_ignt_entry = (r_state == IDLE) && (w_next == IGNT);

  arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk          (CLK),
    .rst          (RST),
    .i_dgnt_entry (w_dgnt_entry),
    .i_ignt_entry (w_ignt_entry),
    .i_iren       (bus.iREN),
    .o_force      (w_force)
  );
`else
  localparam int UNUSED_STARVE_LIMIT = STARVE_LIMIT;
  assign w_force = 1'b0;
`endif

  always_comb begin
    w_next       = r_state;
    w_next_owner = r_owner;
    w_done_ok    = 1'b0;
    w_done_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_dreq && !w_force) begin
          w_next       = DGNT;
          w_next_owner = D;
        end else if (bus.iREN) begin
          w_next       = IGNT;
          w_next_owner = I;
        end
      end
      IGNT, DGNT: begin
        // Completion beats abort: an access the RAM already finished is kept.
        if (bus.ramstate == ACCESS) begin
          w_next    = RESP;
          w_done_ok = 1'b1;
        end else if (bus.ramstate == ERROR || r_tmo == TMO_LIM) begin
          w_next     = RESP;
          w_done_err = 1'b1;
        end else if (!w_own_req) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_load_val = w_done_err ? ARB_ERR_WORD : bus.ramload;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_owner <= I;
      r_tmo   <= '0;
      r_iload <= '0;
      r_dload <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_owner <= w_next_owner;
      if (!w_in_grant)
        r_tmo <= '0;
      else if (r_tmo != 8'hFF)
        r_tmo <= r_tmo + 8'd1;
      if (w_done_ok || w_done_err) begin
        if (r_owner == I)
          r_iload <= w_load_val;
        else
          r_dload <= w_load_val;
      end
      if (w_done_err)
        r_err <= 1'b1;
    end
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (r_state)
      IGNT: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
      end
      DGNT: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (bus.dWEN)
          bus.ramWEN = 1'b1;
        else
          bus.ramREN = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.iload   = r_iload;
  assign bus.dload   = r_dload;
  assign bus.iwait   = !((r_state == RESP) && (r_owner == I));
  assign bus.dwait   = !((r_state == RESP) && (r_owner == D));
  assign bus.ram_err = r_err;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: fetch, contention, write, abort, error,
// timeout, fairness (pattern depends on ARB_FAIRNESS_EN) and async reset.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic CLK;
  logic RST;
  int   n_tests;
  int   n_fail;

  arbiter_if bus_if ();

  memory_arbiter #(.TIMEOUT(255), .STARVE_LIMIT(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if.arb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int         n_gr;
    int         n_busy;
    logic       got;
    logic [5:0] r_is_i;
    logic [5:0] exp_pat;

    n_tests = 0;
    n_fail  = 0;
    RST = 1'b1;
    bus_if.iREN = 1'b0;  bus_if.iaddr = '0;
    bus_if.dREN = 1'b0;  bus_if.dWEN = 1'b0;
    bus_if.daddr = '0;   bus_if.dstore = '0;
    bus_if.ramload = '0; bus_if.ramstate = FREE;

    #12;
    chk("rst_iwait",   32'(bus_if.iwait),   32'd1);
    chk("rst_dwait",   32'(bus_if.dwait),   32'd1);
    chk("rst_ramREN",  32'(bus_if.ramREN),  32'd0);
    chk("rst_ramWEN",  32'(bus_if.ramWEN),  32'd0);
    chk("rst_ramaddr", bus_if.ramaddr,      32'd0);
    chk("rst_iload",   bus_if.iload,        32'd0);
    chk("rst_dload",   bus_if.dload,        32'd0);
    chk("rst_err",     32'(bus_if.ram_err), 32'd0);
    RST = 1'b0;

    // fetch read, ACCESS on the second grant cycle
    bus_if.iREN = 1'b1; bus_if.iaddr = 32'h40; bus_if.ramstate = BUSY;
    tick();
    chk("f_ren1",  32'(bus_if.ramREN), 32'd1);
    chk("f_addr1", bus_if.ramaddr,     32'h40);
    chk("f_wait1", 32'(bus_if.iwait),  32'd1);
    tick();
    chk("f_ren2",  32'(bus_if.ramREN), 32'd1);
    bus_if.ramstate = ACCESS; bus_if.ramload = 32'h2402000A;
    tick();
    chk("f_iwait", 32'(bus_if.iwait),  32'd0);
    chk("f_iload", bus_if.iload,       32'h2402000A);
    chk("f_ren3",  32'(bus_if.ramREN), 32'd0);
    chk("f_dwait", 32'(bus_if.dwait),  32'd1);
    bus_if.iREN = 1'b0;
    tick();
    chk("f_idle_iwait", 32'(bus_if.iwait), 32'd1);

    // contention: data first, fetch afterwards
    bus_if.iREN = 1'b1; bus_if.iaddr = 32'h44;
    bus_if.dREN = 1'b1; bus_if.daddr = 32'h80;
    bus_if.ramload = 32'h11111111;
    tick();
    chk("c_daddr", bus_if.ramaddr,     32'h80);
    chk("c_dren",  32'(bus_if.ramREN), 32'd1);
    chk("c_iwait", 32'(bus_if.iwait),  32'd1);
    tick();
    chk("c_dwait", 32'(bus_if.dwait),  32'd0);
    chk("c_dload", bus_if.dload,       32'h11111111);
    chk("c_iwait2", 32'(bus_if.iwait), 32'd1);
    bus_if.dREN = 1'b0; bus_if.ramload = 32'h22222222;
    tick();
    chk("c_idle_ren", 32'(bus_if.ramREN), 32'd0);
    tick();
    chk("c_iaddr", bus_if.ramaddr,     32'h44);
    chk("c_iren",  32'(bus_if.ramREN), 32'd1);
    tick();
    chk("c_iwait3", 32'(bus_if.iwait), 32'd0);
    chk("c_iload",  bus_if.iload,      32'h22222222);
    bus_if.iREN = 1'b0;
    tick();

    // write wins over read
    bus_if.dREN = 1'b1; bus_if.dWEN = 1'b1;
    bus_if.daddr = 32'h100; bus_if.dstore = 32'hDEADBEEF;
    bus_if.ramstate = BUSY;
    tick();
    chk("w_wen",   32'(bus_if.ramWEN), 32'd1);
    chk("w_ren",   32'(bus_if.ramREN), 32'd0);
    chk("w_store", bus_if.ramstore,    32'hDEADBEEF);
    chk("w_addr",  bus_if.ramaddr,     32'h100);
    bus_if.ramstate = ACCESS; bus_if.ramload = 32'h33333333;
    tick();
    chk("w_dwait", 32'(bus_if.dwait),   32'd0);
    chk("w_dload", bus_if.dload,        32'h33333333);
    chk("w_wen0",  32'(bus_if.ramWEN),  32'd0);
    chk("w_store0", bus_if.ramstore,    32'd0);
    bus_if.dREN = 1'b0; bus_if.dWEN = 1'b0;
    tick();

    // fetch abort during grant
    bus_if.iREN = 1'b1; bus_if.iaddr = 32'h200; bus_if.ramstate = BUSY;
    tick();
    chk("a_ren", 32'(bus_if.ramREN), 32'd1);
    bus_if.iREN = 1'b0;
    tick();
    chk("a_ren0",  32'(bus_if.ramREN), 32'd0);
    chk("a_iwait", 32'(bus_if.iwait),  32'd1);
    tick();
    chk("a_iwait2", 32'(bus_if.iwait), 32'd1);
    chk("a_iload",  bus_if.iload,      32'h22222222);

    // RAM error on a data read
    bus_if.dREN = 1'b1; bus_if.daddr = 32'h300; bus_if.ramstate = ERROR;
    tick();
    chk("e_err_pre", 32'(bus_if.ram_err), 32'd0);
    tick();
    chk("e_dwait", 32'(bus_if.dwait),   32'd0);
    chk("e_dload", bus_if.dload,        32'hBAD1BAD1);
    chk("e_err",   32'(bus_if.ram_err), 32'd1);
    bus_if.dREN = 1'b0; bus_if.ramstate = FREE;
    tick();
    chk("e_sticky", 32'(bus_if.ram_err), 32'd1);
    chk("e_dwait1", 32'(bus_if.dwait),   32'd1);

    // timeout with BUSY held
    bus_if.iREN = 1'b1; bus_if.iaddr = 32'h700; bus_if.ramstate = BUSY;
    n_busy = 0; got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      tick();
      if (bus_if.iwait === 1'b0) got = 1'b1;
      else if (bus_if.ramREN === 1'b1) n_busy++;
    end
    chk("t_done",  32'(got), 32'd1);
    chk("t_len",   32'(n_busy >= 255 && n_busy <= 256), 32'd1);
    chk("t_iload", bus_if.iload,        32'hBAD1BAD1);
    chk("t_err",   32'(bus_if.ram_err), 32'd1);
    bus_if.iREN = 1'b0; bus_if.ramstate = FREE;
    tick();
    chk("t_iwait1", 32'(bus_if.iwait), 32'd1);

    // back-to-back data with constant fetch request
`ifdef ARB_FAIRNESS_EN
    exp_pat = 6'b010000;
`else
    exp_pat = 6'b000000;
`endif
    bus_if.iREN = 1'b1; bus_if.iaddr = 32'h500;
    bus_if.dREN = 1'b1; bus_if.daddr = 32'h400;
    bus_if.ramstate = ACCESS; bus_if.ramload = 32'h44444444;
    n_gr = 0; r_is_i = '0;
    for (int k = 0; k < 40 && n_gr < 6; k++) begin
      tick();
      if (bus_if.ramREN === 1'b1) begin
        r_is_i[n_gr] = (bus_if.ramaddr === 32'h500);
        n_gr++;
      end
    end
    chk("s_ngrants", 32'(n_gr), 32'd6);
    for (int g = 0; g < 6; g++)
      chk($sformatf("s_grant%0d_is_fetch", g), 32'(r_is_i[g]), 32'(exp_pat[g]));
    bus_if.iREN = 1'b0; bus_if.dREN = 1'b0;
    tick();
    bus_if.ramstate = FREE;
    tick();
    tick();

    // asynchronous reset during a data grant
    bus_if.dREN = 1'b1; bus_if.daddr = 32'h600; bus_if.ramstate = BUSY;
    tick();
    chk("r_ren_pre", 32'(bus_if.ramREN), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("r_ren0",  32'(bus_if.ramREN),  32'd0);
    chk("r_addr0", bus_if.ramaddr,      32'd0);
    chk("r_err0",  32'(bus_if.ram_err), 32'd0);
    chk("r_iload", bus_if.iload,        32'd0);
    RST = 1'b0;
    bus_if.dREN = 1'b0;
    tick();
    chk("r_idle_ren",   32'(bus_if.ramREN), 32'd0);
    chk("r_idle_dwait", 32'(bus_if.dwait),  32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
